idct_1d_8pt: RTL and testbench

//  Pipelined 8-point 1-D inverse DCT for the return path of the 1-D DCT stage.
//  - Input: one vector of 8 signed frequency coefficients per cycle.
//  - Output: 8 signed pixel-domain samples, fixed latency, no backpressure.
//  - Feeds the row/column transpose buffer on the decode side.
//  - Result is defined bit-exactly by the integer matrix W below.

---
 rtl/idct_pkg.sv | 58 +++++
 rtl/idct_odd4.sv | 29 ++
 rtl/idct_1d_8pt.sv | 123 ++++++++++++
 tb/tb_idct_1d_8pt.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared constants, types and W matrix for the 8-point 1-D IDCT.
// The bench reuses W as its reference table.
package idct_pkg;
  localparam int IDCT_N = 8;
  localparam int IN_W   = 12;
  localparam int OUT_W  = 8;
  localparam int FRAC   = 8;
  localparam int ACC_W  = 24;
  localparam int WGT_W  = 9;

  typedef logic signed [IN_W-1:0]  coef_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] samp_t;
  typedef logic signed [WGT_W-1:0] wgt_t;

  typedef struct packed {
    samp_t data;
    logic  sat;
  } rnd_t;

  // W[n][k]; rows 4..7 mirror rows 3..0 with odd columns negated.
  localparam wgt_t W [IDCT_N][IDCT_N] = '{
    '{9'sd91,  9'sd126,  9'sd118,  9'sd106, 9'sd91,  9'sd71,   9'sd49,   9'sd25},
    '{9'sd91,  9'sd106,  9'sd49,  -9'sd25, -9'sd91, -9'sd126, -9'sd118, -9'sd71},
    '{9'sd91,  9'sd71,  -9'sd49,  -9'sd126,-9'sd91,  9'sd25,   9'sd118,  9'sd106},
    '{9'sd91,  9'sd25,  -9'sd118, -9'sd71,  9'sd91,  9'sd106, -9'sd49,  -9'sd126},
    '{9'sd91, -9'sd25,  -9'sd118,  9'sd71,  9'sd91, -9'sd106, -9'sd49,   9'sd126},
    '{9'sd91, -9'sd71,  -9'sd49,   9'sd126,-9'sd91, -9'sd25,   9'sd118, -9'sd106},
    '{9'sd91, -9'sd106,  9'sd49,   9'sd25, -9'sd91,  9'sd126, -9'sd118,  9'sd71},
    '{9'sd91, -9'sd126,  9'sd118, -9'sd106, 9'sd91, -9'sd71,   9'sd49,  -9'sd25}
  };

  localparam acc_t HALF    = acc_t'(2**(FRAC-1));
  localparam acc_t SAT_MAX = acc_t'(2**(OUT_W-1) - 1);
  localparam acc_t SAT_MIN = acc_t'(-(2**(OUT_W-1)));

  function automatic acc_t mul(input wgt_t w, input coef_t x);
    return acc_t'(w) * acc_t'(x);
  endfunction

  // Round half up, then clamp to the signed output range.
  function automatic rnd_t sat_round(input acc_t acc);
    acc_t r;
    rnd_t o;
    r = (acc + HALF) >>> FRAC;
    if (r > SAT_MAX) begin
      o.data = SAT_MAX[OUT_W-1:0];
      o.sat  = 1'b1;
    end else if (r < SAT_MIN) begin
      o.data = SAT_MIN[OUT_W-1:0];
      o.sat  = 1'b1;
    end else begin
      o.data = r[OUT_W-1:0];
      o.sat  = 1'b0;
    end
    return o;
  endfunction
endpackage

// File: rtl/idct_odd4.sv
// Odd half of the IDCT: 4x4 products of X[1,3,5,7] against W odd columns, one register stage.
module idct_odd4
  import idct_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic signed [3:0][IN_W-1:0]  i_x,
  output logic signed [3:0][ACC_W-1:0] o_odd
);
  acc_t [3:0] odd_d;

  always_comb begin
    odd_d = '0;
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 4; j++) begin
        odd_d[n] = odd_d[n] + mul(W[n][2*j+1], i_x[j]);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_odd <= '0;
    end else if (i_en) begin
      o_odd <= odd_d;
    end
  end
endmodule

// File: rtl/idct_1d_8pt.sv
// 4-stage pipelined 8-point 1-D IDCT: register, even/odd products, butterfly, round/saturate.
module idct_1d_8pt
  import idct_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic signed [IN_W-1:0]  i_coef0,
  input  logic signed [IN_W-1:0]  i_coef1,
  input  logic signed [IN_W-1:0]  i_coef2,
  input  logic signed [IN_W-1:0]  i_coef3,
  input  logic signed [IN_W-1:0]  i_coef4,
  input  logic signed [IN_W-1:0]  i_coef5,
  input  logic signed [IN_W-1:0]  i_coef6,
  input  logic signed [IN_W-1:0]  i_coef7,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] o_data0,
  output logic signed [OUT_W-1:0] o_data1,
  output logic signed [OUT_W-1:0] o_data2,
  output logic signed [OUT_W-1:0] o_data3,
  output logic signed [OUT_W-1:0] o_data4,
  output logic signed [OUT_W-1:0] o_data5,
  output logic signed [OUT_W-1:0] o_data6,
  output logic signed [OUT_W-1:0] o_data7,
  output logic                    o_sat
);
  logic                v1, v2, v3, v4;
  coef_t [IDCT_N-1:0]  x_q;
  acc_t  [3:0]         even_d, even_q, odd_q;
  acc_t  [IDCT_N-1:0]  acc_q;
  rnd_t  [IDCT_N-1:0]  rnd_d;
  logic                sat_d;
  samp_t [IDCT_N-1:0]  data_q;
  logic                sat_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      {v1, v2, v3, v4} <= '0;
    end else begin
      {v1, v2, v3, v4} <= {i_valid, v1, v2, v3};
    end
  end

  // NOTE: datapath registers are reset as well so o_data*/o_sat read 0 during and after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q <= '0;
    end else if (i_valid) begin
      x_q <= {i_coef7, i_coef6, i_coef5, i_coef4, i_coef3, i_coef2, i_coef1, i_coef0};
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    even_d = '0;
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 4; j++) begin
        even_d[n] = even_d[n] + mul(W[n][2*j], x_q[2*j]);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      even_q <= '0;
    end else if (v1) begin
      even_q <= even_d;
    end
  end

  idct_odd4 u_odd4 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (v1),
    .i_x   ({x_q[7], x_q[5], x_q[3], x_q[1]}),
    .o_odd (odd_q)
  );

  // Butterfly: x[n] = e[n] + o[n], x[7-n] = e[n] - o[n].
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q <= '0;
    end else if (v2) begin
      for (int n = 0; n < 4; n++) begin
        acc_q[n]     <= even_q[n] + odd_q[n];
        acc_q[7 - n] <= even_q[n] - odd_q[n];
      end
    end
  end

  always_comb begin
    rnd_d = '0;
    sat_d = 1'b0;
    for (int n = 0; n < IDCT_N; n++) begin
      rnd_d[n] = sat_round(acc_q[n]);
      sat_d    = sat_d | rnd_d[n].sat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if (v3) begin
      for (int n = 0; n < IDCT_N; n++) begin
        data_q[n] <= rnd_d[n].data;
      end
      sat_q <= sat_d;
    end
  end

  assign o_valid = v4;
  assign o_sat   = sat_q;
  assign o_data0 = data_q[0];
  assign o_data1 = data_q[1];
  assign o_data2 = data_q[2];
  assign o_data3 = data_q[3];
  assign o_data4 = data_q[4];
  assign o_data5 = data_q[5];
  assign o_data6 = data_q[6];
  assign o_data7 = data_q[7];
endmodule

// File: tb/tb_idct_1d_8pt.sv
// Self-checking bench for idct_1d_8pt: directed table, saturation pair, random stream, mid-stream reset.
module tb_idct_1d_8pt;
  import idct_pkg::*;

  typedef coef_t [7:0] cvec_t;
  typedef samp_t [7:0] xvec_t;
  typedef struct packed { cvec_t c; xvec_t x; logic sat; } vec_t;
  typedef struct packed { logic v; xvec_t x; logic sat; } slot_t;

  logic  i_clk = 1'b0;
  logic  i_rst;
  logic  i_valid;
  cvec_t coef;
  logic  o_valid, o_sat;
  samp_t o_data0, o_data1, o_data2, o_data3, o_data4, o_data5, o_data6, o_data7;
  xvec_t dut_x;

  int    checks = 0;
  int    errors = 0;
  int    in_cnt = 0;
  int    out_cnt = 0;
  slot_t pipe [4];
  xvec_t exp_x;
  logic  exp_sat;
  vec_t  tbl [10];

  always #5 i_clk = ~i_clk;

  idct_1d_8pt dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_coef0 (coef[0]), .i_coef1 (coef[1]), .i_coef2 (coef[2]), .i_coef3 (coef[3]),
    .i_coef4 (coef[4]), .i_coef5 (coef[5]), .i_coef6 (coef[6]), .i_coef7 (coef[7]),
    .o_valid (o_valid),
    .o_data0 (o_data0), .o_data1 (o_data1), .o_data2 (o_data2), .o_data3 (o_data3),
    .o_data4 (o_data4), .o_data5 (o_data5), .o_data6 (o_data6), .o_data7 (o_data7),
    .o_sat   (o_sat)
  );

  assign dut_x = {o_data7, o_data6, o_data5, o_data4, o_data3, o_data2, o_data1, o_data0};

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cvec_t cv(input int k, input int val);
    cvec_t c;
    c    = '0;
    c[k] = coef_t'(val);
    return c;
  endfunction

  function automatic xvec_t xv(input int a [8]);
    xvec_t x;
    for (int n = 0; n < 8; n++) x[n] = samp_t'(a[n]);
    return x;
  endfunction

  function automatic xvec_t xall(input int v);
    xvec_t x;
    for (int n = 0; n < 8; n++) x[n] = samp_t'(v);
    return x;
  endfunction

  // Reference: full-precision dot product, floor((acc+128)/256), clamp.
  function automatic slot_t model(input cvec_t c);
    slot_t s;
    int acc, t, q;
    s.v   = 1'b1;
    s.sat = 1'b0;
    for (int n = 0; n < 8; n++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) acc += int'(W[n][k]) * int'(c[k]);
      t = acc + 128;
      q = t / 256;
      if (t % 256 < 0) q--;
      if (q > 127) begin
        q = 127; s.sat = 1'b1;
      end else if (q < -128) begin
        q = -128; s.sat = 1'b1;
      end
      s.x[n] = samp_t'(q);
    end
    return s;
  endfunction

  function automatic cvec_t rnd_vec();
    cvec_t c;
    for (int k = 0; k < 8; k++)
      c[k] = ($urandom_range(0, 1) == 1) ? coef_t'($urandom) : coef_t'(int'($urandom_range(0, 255)) - 128);
    return c;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 4; s++) pipe[s] = '0;
    exp_x   = '0;
    exp_sat = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the latency model, compare on the falling edge.
  task automatic cycle(input logic v, input cvec_t c);
    i_valid = v;
    coef    = c;
    if (v) in_cnt++;
    @(posedge i_clk);
    for (int s = 3; s > 0; s--) pipe[s] = pipe[s-1];
    pipe[0] = v ? model(c) : '0;
    if (pipe[3].v) begin
      exp_x   = pipe[3].x;
      exp_sat = pipe[3].sat;
    end
    @(negedge i_clk);
    if (o_valid) out_cnt++;
    check("o_valid", o_valid, pipe[3].v);
    check("o_data", dut_x, exp_x);
    check("o_sat", o_sat, exp_sat);
  endtask

  task automatic idle();
    cycle(1'b0, rnd_vec());
  endtask

  task automatic check_out(input string name, input xvec_t x, input logic sat);
    check({name, "_valid"}, o_valid, 1'b1);
    check({name, "_data"}, dut_x, x);
    check({name, "_sat"}, o_sat, sat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{c: cv(0, 64),    x: xall(23),  sat: 1'b0};
    tbl[1] = '{c: cv(1, 256),   x: xv('{126, 106, 71, 25, -25, -71, -106, -126}), sat: 1'b0};
    tbl[2] = '{c: cv(2, 256),   x: xv('{118, 49, -49, -118, -118, -49, 49, 118}), sat: 1'b0};
    tbl[3] = '{c: cv(4, 256),   x: xv('{91, -91, -91, 91, 91, -91, -91, 91}),     sat: 1'b0};
    tbl[4] = '{c: cv(7, 256),   x: xv('{25, -71, 106, -126, 126, -106, 71, -25}), sat: 1'b0};
    tbl[5] = '{c: cv(5, -256),  x: xv('{-71, 126, -25, -106, 106, 25, -126, 71}), sat: 1'b0};
    tbl[6] = '{c: cv(0, -64),   x: xall(-23), sat: 1'b0};
    tbl[7] = '{c: cv(0, 100) | cv(1, 50), x: xv('{60, 56, 49, 40, 31, 22, 15, 11}), sat: 1'b0};
    tbl[8] = '{c: cv(0, 2047),  x: xall(127),  sat: 1'b1};
    tbl[9] = '{c: cv(0, -2048), x: xall(-128), sat: 1'b1};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    coef    = '0;
    clear_model();
    repeat (2) @(negedge i_clk);
    check("reset_valid", o_valid, 1'b0);
    check("reset_data", dut_x, '0);
    check("reset_sat", o_sat, 1'b0);
    i_rst = 1'b0;

    // Idle after reset: everything stays zero.
    repeat (10) idle();

    // Single isolated vectors against hand-computed results.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i].c);
      repeat (3) idle();
      check_out($sformatf("tbl%0d", i), tbl[i].x, tbl[i].sat);
    end

    // Positive then negative saturation back to back.
    cycle(1'b1, cv(0, 2047));
    cycle(1'b1, cv(0, -2048));
    idle();
    idle();
    check_out("sat_pos", xall(127), 1'b1);
    idle();
    check_out("sat_neg", xall(-128), 1'b1);
    repeat (3) idle();

    // Random streams with a gap; every output compared by the model each cycle.
    in_cnt  = 0;
    out_cnt = 0;
    repeat (64) cycle(1'b1, rnd_vec());
    repeat (3) idle();
    repeat (16) cycle(1'b1, rnd_vec());
    repeat (4) idle();
    check("valid_count", out_cnt, in_cnt);

    // Mid-stream reset discards three vectors in flight.
    cycle(1'b1, cv(0, 64));
    repeat (3) idle();
    cycle(1'b1, cv(1, 256));
    cycle(1'b1, cv(2, 256));
    cycle(1'b1, cv(4, 256));
    #1 i_rst = 1'b1;
    #1;
    check("async_rst_valid", o_valid, 1'b0);
    check("async_rst_data", dut_x, '0);
    check("async_rst_sat", o_sat, 1'b0);
    clear_model();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (6) idle();
    cycle(1'b1, cv(0, 64));
    repeat (3) idle();
    check_out("post_rst", xall(23), 1'b0);
    repeat (2) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
